// File: rtl/mac_apot4_vec_if.sv
// Operand/result bundle for the APoT dot-product MAC.
// The master drives beats and clears; the slave (the MAC) returns results.
interface mac_apot4_vec_if #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned ACC_WIDTH = 16
);
   logic                        in_valid;
   logic [4*LANES-1:0]          weight;
   logic [4*LANES-1:0]          act;
   logic                        acc_clear;
   logic signed [ACC_WIDTH-1:0] out;
   logic                        out_valid;
   logic                        out_sat;

   modport master (
      output in_valid, weight, act, acc_clear,
      input  out, out_valid, out_sat
   );

   modport slave (
      input  in_valid, weight, act, acc_clear,
      output out, out_valid, out_sat
   );
endinterface

// File: rtl/mac_apot4_vec.sv
// Multi-lane pipelined 4-bit APoT dot-product MAC with a saturating signed accumulator.
// Three stages: operand capture, decode/multiply/lane-sum, accumulate/emit.
module mac_apot4_vec #(
   parameter int unsigned LANES     = 4,
   parameter int unsigned ACC_WIDTH = 16,
   parameter int unsigned VEC_LEN   = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   mac_apot4_vec_if.slave bus
);
   localparam int unsigned SumW = 9 + $clog2(LANES);
   localparam int unsigned CntW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(VEC_LEN - 1);
   localparam logic signed [ACC_WIDTH:0] AccMax = {2'b00, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] AccMin = {2'b11, {(ACC_WIDTH-1){1'b0}}};

   // Sign-magnitude APoT decode: returns {sign, magnitude}; 4'b1000 is the special +5.
   function automatic logic [4:0] decode(input logic [3:0] c);
      logic [3:0] mag;
      mag = '0;
      if (c == 4'b1000) begin
         return 5'b0_0101;
      end
      unique case (c[2:1])
         2'b00: mag = 4'd0;
         2'b01: mag = 4'd8;
         2'b10: mag = 4'd4;
         2'b11: mag = 4'd1;
      endcase
      mag = mag + {2'b00, c[0], 1'b0};
      return {c[3], mag};
   endfunction

   // Signed product of one lane; a zero magnitude always yields +0.
   function automatic logic signed [8:0] lane_prod(input logic [3:0] w, input logic [3:0] a);
      logic [4:0] dw;
      logic [4:0] da;
      logic [7:0] mag;
      dw  = decode(w);
      da  = decode(a);
      mag = {4'b0000, dw[3:0]} * {4'b0000, da[3:0]};
      if ((dw[4] ^ da[4]) && (mag != 8'd0)) begin
         return -$signed({1'b0, mag});
      end
      return $signed({1'b0, mag});
   endfunction

   logic                        r_v1;
   logic [4*LANES-1:0]          r_w1;
   logic [4*LANES-1:0]          r_a1;
   logic                        r_v2;
   logic signed [SumW-1:0]      r_sum2;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic [CntW-1:0]             r_cnt;
   logic                        r_sticky;
   logic                        r_first;
   logic signed [ACC_WIDTH-1:0] r_out;
   logic                        r_out_valid;
   logic                        r_out_sat;

   logic signed [SumW-1:0]      w_sum;
   logic signed [ACC_WIDTH:0]   w_base;
   logic signed [ACC_WIDTH:0]   w_total;
   logic signed [ACC_WIDTH-1:0] w_acc_next;
   logic                        w_sat;

   // S1: capture operand codes; a beat coinciding with acc_clear is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v1 <= 1'b0;
         r_w1 <= '0;
         r_a1 <= '0;
      end else begin
         r_v1 <= bus.in_valid & ~bus.acc_clear;
         if (bus.in_valid) begin
            r_w1 <= bus.weight;
            r_a1 <= bus.act;
         end
      end
   end

   // Full-precision lane sum of the decoded products.
   always_comb begin
      w_sum = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_sum = w_sum + SumW'(lane_prod(r_w1[4*i +: 4], r_a1[4*i +: 4]));
      end
   end

   // S2: register the lane sum.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v2   <= 1'b0;
         r_sum2 <= '0;
      end else begin
         r_v2 <= r_v1 & ~bus.acc_clear;
         if (r_v1) begin
            r_sum2 <= w_sum;
         end
      end
   end

   // Accumulate one extra bit wide, then clamp to the signed ACC_WIDTH range.
   always_comb begin
      w_base     = r_first ? '0 : (ACC_WIDTH+1)'(r_acc);
      w_total    = w_base + (ACC_WIDTH+1)'(r_sum2);
      w_sat      = 1'b0;
      w_acc_next = w_total[ACC_WIDTH-1:0];
      if (w_total > AccMax) begin
         w_acc_next = AccMax[ACC_WIDTH-1:0];
         w_sat      = 1'b1;
      end else if (w_total < AccMin) begin
         w_acc_next = AccMin[ACC_WIDTH-1:0];
         w_sat      = 1'b1;
      end
   end

   // S3: accumulate, count beats, emit the result on the last beat of a vector.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_sticky    <= 1'b0;
         r_first     <= 1'b1;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_out_sat   <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         r_out_sat   <= 1'b0;
         if (r_v2) begin
            r_acc <= w_acc_next;
            if (r_cnt == CntLast) begin
               r_out       <= w_acc_next;
               r_out_valid <= 1'b1;
               r_out_sat   <= r_sticky | w_sat;
               r_cnt       <= '0;
               r_sticky    <= 1'b0;
               r_first     <= 1'b1;
            end else begin
               r_cnt    <= r_cnt + CntW'(1);
               r_sticky <= r_sticky | w_sat;
               r_first  <= 1'b0;
            end
         end
         // Clear restarts collection but leaves the result path alone.
         if (bus.acc_clear) begin
            r_cnt    <= '0;
            r_sticky <= 1'b0;
            r_first  <= 1'b1;
         end
      end
   end

   assign bus.out       = r_out;
   assign bus.out_valid = r_out_valid;
   assign bus.out_sat   = r_out_sat;

endmodule

// File: tb/tb_mac_apot4_vec.sv
// Scoreboard bench for mac_apot4_vec: three instances cover the single-lane decode sweep,
// a 4-lane/4-beat configuration (bubbles, clear, reset) and a long saturating vector.
module tb_mac_apot4_vec;

   typedef struct {
      logic signed [15:0] val;
      logic               sat;
      int                 cyc;
   } exp_t;

   logic clk;
   logic reset_n;
   int   cyc;
   int   checks;
   int   errors;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   // Decoded code values, indexed by the 4-bit code.
   int tab[16] = '{0, 2, 8, 10, 4, 6, 1, 3, 5, -2, -8, -10, -4, -6, -1, -3};

   mac_apot4_vec_if #(.LANES(1), .ACC_WIDTH(16)) ifa ();
   mac_apot4_vec_if #(.LANES(4), .ACC_WIDTH(16)) ifb ();
   mac_apot4_vec_if #(.LANES(4), .ACC_WIDTH(16)) ifc ();

   mac_apot4_vec #(.LANES(1), .ACC_WIDTH(16), .VEC_LEN(1)) u_dut_a (
      .clk(clk), .reset_n(reset_n), .bus(ifa)
   );
   mac_apot4_vec #(.LANES(4), .ACC_WIDTH(16), .VEC_LEN(4)) u_dut_b (
      .clk(clk), .reset_n(reset_n), .bus(ifb)
   );
   mac_apot4_vec #(.LANES(4), .ACC_WIDTH(16), .VEC_LEN(100)) u_dut_c (
      .clk(clk), .reset_n(reset_n), .bus(ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic signed [63:0] act,
                      input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int dot4(input logic [15:0] w, input logic [15:0] a);
      int s;
      s = 0;
      for (int i = 0; i < 4; i++) s += tab[w[4*i +: 4]] * tab[a[4*i +: 4]];
      return s;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_b(input logic [15:0] w, input logic [15:0] a, input logic clr);
      step();
      ifb.in_valid  = 1'b1;
      ifb.acc_clear = clr;
      ifb.weight    = w;
      ifb.act       = a;
   endtask

   task automatic idle_b();
      step();
      ifb.in_valid  = 1'b0;
      ifb.acc_clear = 1'b0;
   endtask

   task automatic push(inout exp_t q[$], input int val, input logic sat, input int at);
      exp_t e;
      e.val = 16'(val);
      e.sat = sat;
      e.cyc = at;
      q.push_back(e);
   endtask

   // Monitors: pop expected results whenever a DUT presents out_valid.
   always @(negedge clk) begin
      exp_t e;
      if (ifa.out_valid === 1'b1) begin
         if (q_a.size() == 0) chk("a_unexpected_valid", 1, 0);
         else begin
            e = q_a.pop_front();
            chk("a_out", ifa.out, e.val);
            chk("a_sat", ifa.out_sat, e.sat);
            chk("a_latency", cyc, e.cyc);
         end
      end else if (ifa.out_sat !== 1'b0) chk("a_sat_idle", ifa.out_sat, 0);
   end

   always @(negedge clk) begin
      exp_t e;
      if (ifb.out_valid === 1'b1) begin
         if (q_b.size() == 0) chk("b_unexpected_valid", 1, 0);
         else begin
            e = q_b.pop_front();
            chk("b_out", ifb.out, e.val);
            chk("b_sat", ifb.out_sat, e.sat);
            chk("b_latency", cyc, e.cyc);
         end
      end else if (ifb.out_sat !== 1'b0) chk("b_sat_idle", ifb.out_sat, 0);
   end

   always @(negedge clk) begin
      exp_t e;
      if (ifc.out_valid === 1'b1) begin
         if (q_c.size() == 0) chk("c_unexpected_valid", 1, 0);
         else begin
            e = q_c.pop_front();
            chk("c_out", ifc.out, e.val);
            chk("c_sat", ifc.out_sat, e.sat);
            chk("c_latency", cyc, e.cyc);
         end
      end else if (ifc.out_sat !== 1'b0) chk("c_sat_idle", ifc.out_sat, 0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      logic [15:0] wv[4];
      logic [15:0] av[4];
      int          gap[4];
      int          sum;

      cyc     = 0;
      checks  = 0;
      errors  = 0;
      reset_n = 1'b0;
      {ifa.in_valid, ifa.acc_clear, ifa.weight, ifa.act} = '0;
      {ifb.in_valid, ifb.acc_clear, ifb.weight, ifb.act} = '0;
      {ifc.in_valid, ifc.acc_clear, ifc.weight, ifc.act} = '0;
      repeat (3) step();
      chk("rst_a_out", ifa.out, 0);
      chk("rst_a_valid", ifa.out_valid, 0);
      chk("rst_b_out", ifb.out, 0);
      chk("rst_b_valid", ifb.out_valid, 0);
      chk("rst_b_sat", ifb.out_sat, 0);
      chk("rst_c_valid", ifc.out_valid, 0);
      reset_n = 1'b1;
      step();

      // 4 beats of code 0110 (+1) on all lanes: 4 per beat -> 16.
      for (int i = 0; i < 4; i++) beat_b(16'h6666, 16'h6666, 1'b0);
      push(q_b, 16, 1'b0, cyc + 3);
      idle_b();
      repeat (6) step();

      // Mixed codes with in_valid gaps; result checked against the table model.
      wv  = '{16'h8A31, 16'hF0C2, 16'h1357, 16'h9BDF};
      av  = '{16'h2F08, 16'h8888, 16'hE6A4, 16'h3210};
      gap = '{0, 2, 0, 1};
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < gap[i]; g++) idle_b();
         beat_b(wv[i], av[i], 1'b0);
         sum += dot4(wv[i], av[i]);
      end
      push(q_b, sum, 1'b0, cyc + 3);
      // Back-to-back second vector.
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         beat_b(av[i], wv[i] ^ 16'h8421, 1'b0);
         sum += dot4(av[i], wv[i] ^ 16'h8421);
      end
      push(q_b, sum, 1'b0, cyc + 3);
      idle_b();
      repeat (6) step();

      // Two beats, a clear (its own beat dropped), then four fresh beats.
      beat_b(16'h3333, 16'h3333, 1'b0);
      beat_b(16'h3333, 16'h3333, 1'b0);
      beat_b(16'h3333, 16'h3333, 1'b1);
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         beat_b(wv[i], 16'h8888, 1'b0);
         sum += dot4(wv[i], 16'h8888);
      end
      push(q_b, sum, 1'b0, cyc + 3);
      idle_b();
      repeat (6) step();

      // Async reset mid-vector clears outputs at once; next full vector is clean.
      beat_b(16'h3333, 16'h3333, 1'b0);
      beat_b(16'h3333, 16'h3333, 1'b0);
      idle_b();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_b_out", ifb.out, 0);
      chk("arst_b_valid", ifb.out_valid, 0);
      chk("arst_a_out", ifa.out, 0);
      step();
      reset_n = 1'b1;
      step();
      for (int i = 0; i < 4; i++) beat_b(16'hE6A4, 16'h0123, 1'b0);
      push(q_b, 4 * dot4(16'hE6A4, 16'h0123), 1'b0, cyc + 3);
      idle_b();
      repeat (6) step();

      // Single-lane sweep of all code pairs, back-to-back, one result per beat.
      for (int w = 0; w < 16; w++) begin
         for (int a = 0; a < 16; a++) begin
            step();
            ifa.in_valid = 1'b1;
            ifa.weight   = 4'(w);
            ifa.act      = 4'(a);
            push(q_a, tab[w] * tab[a], 1'b0, cyc + 3);
         end
      end
      step();
      ifa.in_valid = 1'b0;
      repeat (6) step();

      // Saturation: +400/beat x100 clamps high; +4/beat x100 is clean; -400/beat clamps low.
      for (int i = 0; i < 100; i++) begin
         step();
         ifc.in_valid = 1'b1;
         ifc.weight   = 16'h3333;
         ifc.act      = 16'h3333;
      end
      push(q_c, 32767, 1'b1, cyc + 3);
      for (int i = 0; i < 100; i++) begin
         step();
         ifc.weight = 16'h6666;
         ifc.act    = 16'h6666;
      end
      push(q_c, 400, 1'b0, cyc + 3);
      for (int i = 0; i < 100; i++) begin
         step();
         ifc.weight = 16'hBBBB;
         ifc.act    = 16'h3333;
      end
      push(q_c, -32768, 1'b1, cyc + 3);
      step();
      ifc.in_valid = 1'b0;
      repeat (8) step();

      chk("a_pending", q_a.size(), 0);
      chk("b_pending", q_b.size(), 0);
      chk("c_pending", q_c.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
